hash_result_tx: RTL and testbench

Result transmitter for the SHA-256 mining core. It takes the eight 32-bit hash words `h1`..`h8` and the nonce that produced them, and checks the hash against a leading-zero difficulty target. Each qualifying result is serialized as a framed byte stream on an 8N1 UART line to the host. It sits downstream of the `super` hash pipeline and is the design's only path for results leaving the chip.

---
 rtl/hash_pkg.sv | 16 +
 rtl/uart_tx_byte.sv | 98 +++++++++
 rtl/hash_result_tx.sv | 129 ++++++++++++
 tb/tb_hash_result_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared constants and frame-state encoding for the hash result transmitter.
package hash_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         FRAME_BYTES   = 38;
    localparam int         PAYLOAD_BYTES = 36;
    localparam int         HASH_WORDS    = 8;
    localparam int         IDX_W         = 6;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LOAD,
        F_SEND
    } frame_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. The stop bit can roll straight into the next start bit,
// so consecutive bytes leave no idle gap on the line.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    byte_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);
    // Combinational so the parent can issue the next start in the last stop-bit cycle.
    assign done    = (state == B_STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= B_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                B_IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        cnt   <= '0;
                        state <= B_START;
                    end
                end
                B_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= B_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= B_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (start) begin
                            shreg <= data;
                            tx    <= 1'b0;
                            state <= B_START;
                        end else begin
                            state <= B_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= B_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/hash_result_tx.sv
// Qualifies hashes against a leading-zero target and ships each accepted
// nonce+hash as a 38-byte checksummed UART frame.
module hash_result_tx
    import hash_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TARGET_ZEROS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hash_valid,
    input  logic [31:0] h1,
    input  logic [31:0] h2,
    input  logic [31:0] h3,
    input  logic [31:0] h4,
    input  logic [31:0] h5,
    input  logic [31:0] h6,
    input  logic [31:0] h7,
    input  logic [31:0] h8,
    input  logic [31:0] nonce,
    output logic        tx,
    output logic        busy,
    output logic        found,
    output logic [7:0]  drop_cnt
);

    localparam int HASH_BITS   = HASH_WORDS * 32;
    localparam int SHADOW_BITS = PAYLOAD_BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    function automatic logic qualifies(input logic [HASH_BITS-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < HASH_BITS; i++) begin
            if ((i < TARGET_ZEROS) && v[HASH_BITS-1-i]) ok = 1'b0;
        end
        return ok;
    endfunction

    // k counts payload bytes from 1 (nonce MSB) to PAYLOAD_BYTES (h8 LSB).
    function automatic logic [7:0] payload_byte(input logic [SHADOW_BITS-1:0] s,
                                                input logic [IDX_W-1:0] k);
        return 8'(s >> (8 * (PAYLOAD_BYTES - int'(k))));
    endfunction

    frame_state_t           state;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       next_idx;
    logic [SHADOW_BITS-1:0] shadow;
    logic [7:0]             csum;
    logic [HASH_BITS-1:0]   hash_vec;
    logic                   qual;
    logic                   accept;
    logic                   drop;
    logic                   byte_start;
    logic [7:0]             byte_data;
    logic                   byte_done;

    assign hash_vec = {h1, h2, h3, h4, h5, h6, h7, h8};
    assign qual     = qualifies(hash_vec);
    assign accept   = hash_valid && qual && !busy;
    assign drop     = hash_valid && qual && busy;
    assign next_idx = idx + 1'b1;

    // The next byte is handed over in the same cycle the current stop bit ends.
    always_comb begin
        byte_start = 1'b0;
        byte_data  = SYNC_BYTE;
        if (state == F_LOAD) begin
            byte_start = 1'b1;
        end else if ((state == F_SEND) && byte_done && (idx != LAST_IDX)) begin
            byte_start = 1'b1;
            byte_data  = (next_idx == LAST_IDX) ? csum : payload_byte(shadow, next_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= F_IDLE;
            busy     <= 1'b0;
            found    <= 1'b0;
            drop_cnt <= '0;
            idx      <= '0;
        end else begin
            found <= accept;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
            case (state)
                F_IDLE: begin
                    // busy lingers one extra cycle after the last stop bit.
                    if (accept) begin
                        shadow <= {nonce, hash_vec};
                        busy   <= 1'b1;
                        state  <= F_LOAD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                F_LOAD: begin
                    idx   <= '0;
                    csum  <= '0;
                    state <= F_SEND;
                end
                F_SEND: begin
                    if (byte_done) begin
                        if (idx == LAST_IDX) begin
                            state <= F_IDLE;
                        end else begin
                            idx <= next_idx;
                            if (next_idx != LAST_IDX) csum <= csum ^ byte_data;
                        end
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .start(byte_start),
        .data (byte_data),
        .tx   (tx),
        .done (byte_done)
    );

endmodule

// File: tb/tb_hash_result_tx.sv
// Directed bench: frames decoded off the UART line are scored against a queue
// of bytes built from each accepted hash.
module tb_hash_result_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hv;
    logic        hv0;
    logic [31:0] h1, h2, h3, h4, h5, h6, h7, h8, nonce;
    logic        tx, busy, found;
    logic [7:0]  drop_cnt;
    logic        tx0, busy0, found0;
    logic [7:0]  drop_cnt0;

    int          checks = 0;
    int          failures = 0;
    int          rx_bytes = 0;
    logic [7:0]  exp_q[$];
    logic        sel = 1'b0;

    always #5 clk = ~clk;

    hash_result_tx #(.CLKS_PER_BIT(CPB), .TARGET_ZEROS(32)) dut (
        .clk(clk), .rst(rst), .hash_valid(hv),
        .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7), .h8(h8),
        .nonce(nonce), .tx(tx), .busy(busy), .found(found), .drop_cnt(drop_cnt)
    );

    hash_result_tx #(.CLKS_PER_BIT(CPB), .TARGET_ZEROS(0)) dut0 (
        .clk(clk), .rst(rst), .hash_valid(hv0),
        .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7), .h8(h8),
        .nonce(nonce), .tx(tx0), .busy(busy0), .found(found0), .drop_cnt(drop_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [31:0] n, input logic [255:0] hb);
        logic [287:0] b;
        logic [7:0]   cs;
        b  = {n, hb};
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 36; k++) begin
            exp_q.push_back(b[287-8*k -: 8]);
            cs ^= b[287-8*k -: 8];
        end
        exp_q.push_back(cs);
    endtask

    task automatic set_hash(input logic [31:0] n, input logic [255:0] hb);
        nonce = n;
        {h1, h2, h3, h4, h5, h6, h7, h8} = hb;
    endtask

    task automatic wait_idle(input logic use0, input string tag);
        int n;
        n = 0;
        while (((use0 ? busy0 : busy) !== 1'b0) && (n < 4000)) begin
            tick();
            n++;
        end
        check(tag, use0 ? busy0 : busy, 1'b0);
    endtask

    // UART line monitor, sampling at mid-bit on the falling edge.
    logic       mtx;
    logic       ract = 1'b0;
    int         rcnt = 0;
    logic [7:0] rbyte = 8'h00;
    assign mtx = sel ? tx0 : tx;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            ract = 1'b0;
        end else if (!ract) begin
            if (mtx === 1'b0) begin
                ract = 1'b1;
                rcnt = 0;
            end
        end else begin
            rcnt++;
            if ((rcnt % CPB == CPB / 2) && (rcnt / CPB >= 1) && (rcnt / CPB <= 8))
                rbyte[rcnt/CPB-1] = mtx;
            if (rcnt == 9 * CPB + CPB / 2) begin
                check("stop_bit", mtx, 1'b1);
                check("byte_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) check($sformatf("rx_byte%0d", rx_bytes), rbyte, exp_q.pop_front());
                rx_bytes++;
            end
            if (rcnt == 10 * CPB - 1) ract = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int   base;
        int   nbusy;
        int   n;
        logic bad_tx, bad_found, bad_busy;

        rst = 1'b1; hv = 1'b0; hv0 = 1'b0;
        set_hash(32'h0, 256'h0);

        // 1. Reset
        tick(); tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_found", found, 1'b0);
        check("rst_drop", drop_cnt, 8'd0);
        rst = 1'b0;
        bad_tx = 1'b0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1) bad_tx = 1'b1;
        end
        check("idle_tx_high", bad_tx, 1'b0);

        // 2. Qualifying hash, full frame and busy length
        base = rx_bytes;
        set_hash(32'hDEADBEEF, {32'h0, 32'h12345678, 192'h0});
        push_frame(32'hDEADBEEF, {32'h0, 32'h12345678, 192'h0});
        hv = 1'b1;
        tick(); hv = 1'b0;
        check("acc_found", found, 1'b1);
        check("acc_busy", busy, 1'b1);
        check("acc_tx_idle", tx, 1'b1);
        nbusy = busy ? 1 : 0;
        tick();
        check("found_one_cycle", found, 1'b0);
        check("start_bit_n2", tx, 1'b0);
        if (busy) nbusy++;
        n = 0;
        while (n < 4000) begin
            tick();
            n++;
            if (busy === 1'b1) nbusy++;
            else break;
        end
        check("busy_cycles", nbusy, 2 + 380 * CPB);
        check("frame1_bytes", rx_bytes - base, 38);
        check("frame1_queue_empty", exp_q.size(), 0);

        // 3. Non-qualifying hash
        set_hash(32'h11111111, {32'h00000001, 224'h0});
        hv = 1'b1;
        tick(); hv = 1'b0;
        bad_tx = 1'b0; bad_found = 1'b0; bad_busy = 1'b0;
        repeat (60) begin
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (found !== 1'b0) bad_found = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
            tick();
        end
        check("nq_found", bad_found, 1'b0);
        check("nq_busy", bad_busy, 1'b0);
        check("nq_tx", bad_tx, 1'b0);

        // 4. Drop counting
        base = rx_bytes;
        set_hash(32'h01020304, {32'h0, 32'hCAFEF00D, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6});
        push_frame(32'h01020304, {32'h0, 32'hCAFEF00D, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6});
        hv = 1'b1;
        tick(); hv = 1'b0;
        repeat (100) tick();
        set_hash(32'h99999999, {32'h0, 32'hFFFF0000, 192'h0});
        hv = 1'b1;
        tick(); hv = 1'b0;
        check("drop_one", drop_cnt, 8'd1);
        check("drop_no_found", found, 1'b0);
        wait_idle(1'b0, "drop1_idle_timeout");
        check("drop1_bytes", rx_bytes - base, 38);
        check("drop1_queue_empty", exp_q.size(), 0);

        base = rx_bytes;
        set_hash(32'hA0B0C0D0, {32'h0, 32'h0, 32'h77, 160'h0});
        push_frame(32'hA0B0C0D0, {32'h0, 32'h0, 32'h77, 160'h0});
        hv = 1'b1;
        tick(); hv = 1'b0;
        repeat (10) tick();
        set_hash(32'h55555555, {32'h0, 32'h80000000, 192'h0});
        hv = 1'b1;
        repeat (300) tick();
        hv = 1'b0;
        check("drop_saturate", drop_cnt, 8'd255);
        wait_idle(1'b0, "drop2_idle_timeout");
        check("drop2_bytes", rx_bytes - base, 38);
        check("drop2_queue_empty", exp_q.size(), 0);

        // 5. Reset mid-frame, with a simultaneous strobe
        base = rx_bytes;
        set_hash(32'h0BADF00D, {32'h0, 32'h00012345, 192'h0});
        push_frame(32'h0BADF00D, {32'h0, 32'h00012345, 192'h0});
        hv = 1'b1;
        tick(); hv = 1'b0;
        n = 0;
        while ((rx_bytes - base < 10) && (n < 4000)) begin
            tick();
            n++;
        end
        check("reach_byte10", (rx_bytes - base >= 10), 1'b1);
        repeat (12) tick();
        rst = 1'b1;
        set_hash(32'h12121212, 256'h0);
        hv = 1'b1;
        tick(); hv = 1'b0;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_found", found, 1'b0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("postrst_busy", busy, 1'b0);
        check("postrst_tx", tx, 1'b1);
        base = rx_bytes;
        set_hash(32'hFEEDFACE, {32'h0, 32'h0000ABCD, 32'h1, 160'h0});
        push_frame(32'hFEEDFACE, {32'h0, 32'h0000ABCD, 32'h1, 160'h0});
        hv = 1'b1;
        tick(); hv = 1'b0;
        check("postrst_found", found, 1'b1);
        wait_idle(1'b0, "postrst_idle_timeout");
        check("postrst_bytes", rx_bytes - base, 38);
        check("postrst_queue_empty", exp_q.size(), 0);

        // 6. Back-to-back frames with no difficulty target
        sel = 1'b1;
        repeat (3) tick();
        base = rx_bytes;
        set_hash(32'h13579BDF, {32'hFFFFFFFF, 32'h01234567, 192'h0});
        push_frame(32'h13579BDF, {32'hFFFFFFFF, 32'h01234567, 192'h0});
        hv0 = 1'b1;
        tick(); hv0 = 1'b0;
        check("b2b_found1", found0, 1'b1);
        check("b2b_busy1", busy0, 1'b1);
        wait_idle(1'b1, "b2b_first_idle_timeout");
        set_hash(32'h2468ACE0, {32'h80000000, 32'h0, 32'h3C3C3C3C, 160'h0});
        push_frame(32'h2468ACE0, {32'h80000000, 32'h0, 32'h3C3C3C3C, 160'h0});
        hv0 = 1'b1;
        tick(); hv0 = 1'b0;
        check("b2b_found2", found0, 1'b1);
        check("b2b_busy2", busy0, 1'b1);
        check("b2b_tx_idle", tx0, 1'b1);
        tick();
        check("b2b_start_bit", tx0, 1'b0);
        wait_idle(1'b1, "b2b_second_idle_timeout");
        check("b2b_bytes", rx_bytes - base, 76);
        check("b2b_queue_empty", exp_q.size(), 0);
        check("b2b_drop", drop_cnt0, 8'd0);

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
